// File: rtl/xdma_arb.sv
// ---------------------------------------------------------------------------
// xdma_arb: single-channel DMA engine and data-bus arbiter. It sits between
// the picoVersat controller's data bus and the data memory, and copies LEN
// words from SRC to DST. It only uses bus cycles the controller leaves idle,
// because the controller cannot be stalled.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   cpu_sel/we/addr/wdata/rdata  controller data bus (slave side)
//   mem_sel/we/addr/wdata/rdata  data memory bus (master side; rdata is
//                                combinational, returned in the same cycle)
//   busy                         transfer in progress
//   done                         sticky transfer-complete flag
//
// Register map, relative to DMA_BASE:
//   +0 SRC, +1 DST, +2 LEN   read/write; ignored while busy; zero-extended on read
//   +3 CTRL                  write: bit0 start, bit1 clear done
//                            read:  {.., done, busy}
// ---------------------------------------------------------------------------
module xdma_arb #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 13,
  parameter logic [ADDR_W-1:0] DMA_BASE = 13'h1FF0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_sel,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_sel,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              done_q, done_d;

  // Offset from the register base. The unsigned subtraction wraps, so a single
  // "< 4" compare decodes the whole window.
  logic [ADDR_W-1:0] reg_off;
  logic [1:0]        reg_idx;
  logic              cpu_dma;
  logic              cpu_own;
  logic              dma_grant;
  logic              reg_we;

  assign reg_off   = cpu_addr - DMA_BASE;
  assign reg_idx   = reg_off[1:0];
  assign cpu_dma   = cpu_sel && (reg_off < ADDR_W'(4));
  assign cpu_own   = cpu_sel && !cpu_dma;
  assign dma_grant = !cpu_own && (state_q != IDLE);
  assign reg_we    = cpu_dma && cpu_we;

  assign busy = (state_q != IDLE);
  assign done = done_q;

  // Next-state logic: register writes and DMA progress never overlap, because
  // pointer writes are gated by busy and a start is only accepted in IDLE.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    buf_d   = buf_q;
    done_d  = done_q;

    if (reg_we && !busy) begin
      case (reg_idx)
        2'd0:    src_d = cpu_wdata[ADDR_W-1:0];
        2'd1:    dst_d = cpu_wdata[ADDR_W-1:0];
        2'd2:    len_d = cpu_wdata[ADDR_W-1:0];
        default: ;
      endcase
    end

    // Clear is applied before start, so an accepted start decides the final done.
    if (reg_we && reg_idx == 2'd3) begin
      if (cpu_wdata[1]) done_d = 1'b0;
      if (cpu_wdata[0] && state_q == IDLE) begin
        if (len_q != '0) begin
          state_d = RD;
          done_d  = 1'b0;
        end else begin
          done_d = 1'b1;
        end
      end
    end

    if (dma_grant) begin
      case (state_q)
        RD: begin
          buf_d   = mem_rdata;
          src_d   = src_q + ADDR_W'(1);
          state_d = WR;
        end
        WR: begin
          dst_d = dst_q + ADDR_W'(1);
          len_d = len_q - ADDR_W'(1);
          if (len_q == ADDR_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = RD;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      // NOTE: the word buffer is a plain register, not a RAM, so resetting it is cheap and deterministic.
      buf_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      buf_q   <= buf_d;
      done_q  <= done_d;
    end
  end

  // Bus arbitration: the controller always wins; the DMA gets idle cycles.
  always_comb begin
    mem_sel   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_own) begin
      mem_sel   = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dma_grant) begin
      mem_sel = 1'b1;
      if (state_q == WR) begin
        mem_we    = 1'b1;
        mem_addr  = dst_q;
        mem_wdata = buf_q;
      end else begin
        mem_addr = src_q;
      end
    end
  end

  // Read mux: register file on a DMA decode, memory data otherwise.
  always_comb begin
    cpu_rdata = mem_rdata;
    if (cpu_dma) begin
      case (reg_idx)
        2'd0:    cpu_rdata = {{(DATA_W-ADDR_W){1'b0}}, src_q};
        2'd1:    cpu_rdata = {{(DATA_W-ADDR_W){1'b0}}, dst_q};
        2'd2:    cpu_rdata = {{(DATA_W-ADDR_W){1'b0}}, len_q};
        default: cpu_rdata = {{(DATA_W-2){1'b0}}, done_q, busy};
      endcase
    end
  end

endmodule

// File: tb/tb_xdma_arb.sv
// ---------------------------------------------------------------------------
// tb_xdma_arb: directed self-checking bench for xdma_arb. A behavioural data
// memory hangs off the mem_* bus; the bench plays the controller.
// ---------------------------------------------------------------------------
module tb_xdma_arb;

  localparam int          DATA_W = 32;
  localparam int          ADDR_W = 13;
  localparam logic [12:0] R_SRC  = 13'h1FF0;
  localparam logic [12:0] R_DST  = 13'h1FF1;
  localparam logic [12:0] R_LEN  = 13'h1FF2;
  localparam logic [12:0] R_CTRL = 13'h1FF3;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_sel, cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
  logic              mem_sel, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              busy, done;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  int                sel_cnt = 0;
  int                wr_cnt  = 0;

  int total = 0;
  int bad   = 0;

  xdma_arb dut (
    .clk(clk), .rst(rst),
    .cpu_sel(cpu_sel), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .mem_sel(mem_sel), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_sel) sel_cnt = sel_cnt + 1;
    if (mem_sel && mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wr_cnt = wr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic cpu_wr(input logic [12:0] a, input logic [31:0] d);
    @(negedge clk);
    cpu_sel = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
    @(negedge clk);
    cpu_sel = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
  endtask

  task automatic cpu_rd(input logic [12:0] a, output logic [31:0] d);
    @(negedge clk);
    cpu_sel = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    #1 d = cpu_rdata;
    @(negedge clk);
    cpu_sel = 1'b0; cpu_addr = '0;
  endtask

  // Counts busy cycles from the current negedge until busy drops (bounded).
  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
    if (busy) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic setup(input logic [12:0] s, input logic [12:0] d, input logic [12:0] l);
    cpu_wr(R_SRC, {19'd0, s});
    cpu_wr(R_DST, {19'd0, d});
    cpu_wr(R_LEN, {19'd0, l});
  endtask

  logic [31:0] rd;
  int          cyc, n, base;
  logic [31:0] pat [0:3];

  initial begin
    pat[0] = 32'hA0A0_0001; pat[1] = 32'hB1B1_0002;
    pat[2] = 32'hC2C2_0003; pat[3] = 32'hD3D3_0004;
    cpu_sel = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    rst = 1'b1;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_mem_sel", {31'd0, mem_sel}, 32'd0);
    check("rst_mem_addr", {19'd0, mem_addr}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Config and readback: register traffic never reaches memory.
    base = sel_cnt;
    setup(13'h010, 13'h100, 13'd4);
    cpu_rd(R_SRC, rd);  check("cfg_src", rd, 32'h010);
    cpu_rd(R_DST, rd);  check("cfg_dst", rd, 32'h100);
    cpu_rd(R_LEN, rd);  check("cfg_len", rd, 32'h4);
    cpu_rd(R_CTRL, rd); check("cfg_ctrl", rd, 32'h0);
    check("cfg_no_mem", sel_cnt - base, 32'd0);

    // Uncontended copy of four words.
    for (int i = 0; i < 4; i++) cpu_wr(13'h010 + 13'(i), pat[i]);
    cpu_wr(R_CTRL, 32'h1);
    wait_idle(cyc);
    check("copy_cycles", cyc, 32'd8);
    check("copy_done", {31'd0, done}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      cpu_rd(13'h100 + 13'(i), rd);
      check($sformatf("copy_data%0d", i), rd, pat[i]);
    end
    cpu_rd(R_LEN, rd);  check("copy_len", rd, 32'h0);
    cpu_rd(R_SRC, rd);  check("copy_src", rd, 32'h014);
    cpu_rd(R_DST, rd);  check("copy_dst", rd, 32'h104);
    cpu_rd(R_CTRL, rd); check("copy_ctrl", rd, 32'h2);

    // Contention: controller owns every other cycle.
    setup(13'h010, 13'h200, 13'd4);
    cpu_wr(R_CTRL, 32'h1);
    check("cont_done_cleared", {31'd0, done}, 32'd0);
    cyc = 0; n = 0;
    while (busy && cyc < 200) begin
      if (cyc % 2 == 0) begin
        cpu_sel = 1'b1; cpu_we = n[0]; cpu_addr = 13'h800 + 13'(n);
        cpu_wdata = 32'h5A00_0000 + n;
        #1;
        check("cont_addr", {19'd0, mem_addr}, 32'h800 + n);
        check("cont_we", {31'd0, mem_we}, {31'd0, n[0]});
        n++;
      end else begin
        cpu_sel = 1'b0; cpu_we = 1'b0;
      end
      cyc++;
      @(negedge clk);
    end
    cpu_sel = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    check("cont_cycles", cyc, 32'(8 + n));
    check("cont_done", {31'd0, done}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      cpu_rd(13'h200 + 13'(i), rd);
      check($sformatf("cont_data%0d", i), rd, pat[i]);
    end

    // LEN=0 start: done next cycle, no DMA bus traffic.
    cpu_wr(R_CTRL, 32'h2);
    check("len0_cleared", {31'd0, done}, 32'd0);
    cpu_wr(R_LEN, 32'h0);
    base = sel_cnt;
    cpu_wr(R_CTRL, 32'h1);
    check("len0_done", {31'd0, done}, 32'd1);
    check("len0_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    check("len0_no_mem", sel_cnt - base, 32'd0);

    // Writes and start while busy are ignored.
    setup(13'h010, 13'h300, 13'd4);
    cpu_wr(R_CTRL, 32'h3);
    cpu_wr(R_SRC, 32'h555);
    cpu_wr(R_CTRL, 32'h1);
    wait_idle(cyc);
    @(negedge clk);
    check("busywr_idle", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      cpu_rd(13'h300 + 13'(i), rd);
      check($sformatf("busywr_data%0d", i), rd, pat[i]);
    end
    cpu_rd(R_SRC, rd); check("busywr_src", rd, 32'h014);
    cpu_rd(R_DST, rd); check("busywr_dst", rd, 32'h304);

    // Address wrap on the source side.
    cpu_wr(13'h1FFE, 32'h1111_0000);
    cpu_wr(13'h1FFF, 32'h2222_0001);
    cpu_wr(13'h0000, 32'h3333_0002);
    setup(13'h1FFE, 13'h400, 13'd3);
    cpu_wr(R_CTRL, 32'h1);
    wait_idle(cyc);
    check("wrap_cycles", cyc, 32'd6);
    cpu_rd(13'h400, rd); check("wrap_d0", rd, 32'h1111_0000);
    cpu_rd(13'h401, rd); check("wrap_d1", rd, 32'h2222_0001);
    cpu_rd(13'h402, rd); check("wrap_d2", rd, 32'h3333_0002);
    cpu_rd(R_SRC, rd);   check("wrap_src", rd, 32'h001);

    // Reset right after the first WR aborts the transfer.
    for (int i = 0; i < 3; i++) cpu_wr(13'h500 + 13'(i), 32'hDEAD_BEEF);
    setup(13'h1FFE, 13'h500, 13'd3);
    cpu_wr(R_CTRL, 32'h1);
    base = wr_cnt;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_sel", {31'd0, mem_sel}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_one_write", wr_cnt - base, 32'd1);
    cpu_rd(13'h500, rd); check("rst_d0", rd, 32'h1111_0000);
    cpu_rd(13'h501, rd); check("rst_d1", rd, 32'hDEAD_BEEF);
    cpu_rd(R_SRC, rd);   check("rst_src", rd, 32'h0);
    cpu_rd(R_DST, rd);   check("rst_dst", rd, 32'h0);
    cpu_rd(R_LEN, rd);   check("rst_len", rd, 32'h0);
    cpu_rd(R_CTRL, rd);  check("rst_ctrl", rd, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
